// File: rtl/vic_pkg.sv
// Shared constants and state encoding for the vectored interrupt controller.
// vic_irq and vic_vector both import this so the event ID field stays in step.
package vic_pkg;

  localparam int NUM_SRC     = 31;
  localparam int ID_W        = 5;
  localparam int VEC_W       = 32;
  localparam int ACK_TIMEOUT = 64;

  // Event ID that vic_irq never produces for a real source; vic_vector ignores it.
  localparam logic [ID_W-1:0] EVT_ID_NONE = ID_W'(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SERVICE,
    ST_DONE
  } vic_state_e;

endpackage

// File: rtl/vic_prio_enc.sv
// Lowest-set-bit priority encoder: source 0 has the highest priority.
// Purely combinational; valid is low when no request bit is set.
module vic_prio_enc #(
  parameter int NUM_SRC = vic_pkg::NUM_SRC,
  parameter int ID_W    = vic_pkg::ID_W
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vic_vector.sv
// Pending capture, fixed-priority dispatch, vector lookup and CPU request/ack/return
// handshake for interrupt events coming from vic_irq.
module vic_vector #(
  parameter int NUM_SRC     = vic_pkg::NUM_SRC,
  parameter int ID_W        = vic_pkg::ID_W,
  parameter int VEC_W       = vic_pkg::VEC_W,
  parameter int ACK_TIMEOUT = vic_pkg::ACK_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_irq,
  input  logic [ID_W-1:0]  i_irq_addr,
  input  logic             i_wr_en,
  input  logic [ID_W-1:0]  i_wr_addr,
  input  logic [VEC_W-1:0] i_wr_data,
  input  logic             i_cpu_ack,
  input  logic             i_cpu_reti,
  output logic             o_cpu_irq,
  output logic [VEC_W-1:0] o_vector,
  output logic [ID_W-1:0]  o_cur_id,
  output logic             o_in_service,
  output logic             o_eoi,
  output logic             o_overrun
);

  import vic_pkg::*;

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  vic_state_e         state;
  vic_state_e         state_nxt;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] pending_set;
  logic [NUM_SRC-1:0] pending_clr;
  logic [VEC_W-1:0]   vec_table [NUM_SRC];
  logic [CNT_W-1:0]   ack_cnt;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid;
  logic               evt_valid;
  logic               wr_valid;
  logic               dispatch;
  logic               timeout;

  assign evt_valid = i_irq && (int'(i_irq_addr) < NUM_SRC);
  assign wr_valid  = i_wr_en && (int'(i_wr_addr) < NUM_SRC);

  vic_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (pending),
    .id    (sel_id),
    .valid (sel_valid)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // An ack in the same cycle as the timeout limit is honoured rather than abandoned.
  always_comb begin
    state_nxt = state;
    dispatch  = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_en && sel_valid) begin
          dispatch  = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_cpu_ack) begin
          state_nxt = ST_SERVICE;
        end else if ((ACK_TIMEOUT != 0) && (ack_cnt == CNT_LAST)) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (i_cpu_reti) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sets are OR-ed in after the dispatch clear so a same-cycle event on that ID survives.
  always_comb begin
    pending_set = '0;
    pending_clr = '0;
    if (evt_valid) begin
      pending_set = pending_set | (NUM_SRC'(1) << i_irq_addr);
    end
    if (timeout) begin
      pending_set = pending_set | (NUM_SRC'(1) << o_cur_id);
    end
    if (dispatch) begin
      pending_clr = NUM_SRC'(1) << sel_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pending   <= '0;
      o_overrun <= 1'b0;
    end else begin
      pending   <= (pending & ~pending_clr) | pending_set;
      o_overrun <= evt_valid && pending[i_irq_addr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_cnt <= '0;
    end else if ((state == ST_REQ) && !i_cpu_ack && !timeout) begin
      ack_cnt <= ack_cnt + CNT_W'(1);
    end else begin
      ack_cnt <= '0;
    end
  end

  // The vector is captured once at dispatch so later table writes cannot disturb a live service.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_cur_id <= '0;
      o_vector <= '0;
    end else if (dispatch) begin
      o_cur_id <= sel_id;
      o_vector <= vec_table[sel_id];
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_valid) begin
      vec_table[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_cpu_irq    = (state == ST_REQ);
  assign o_in_service = (state == ST_REQ) || (state == ST_SERVICE);
  assign o_eoi        = (state == ST_DONE);

endmodule

// File: tb/tb_vic_vector.sv
// Self-checking bench for vic_vector: directed handshake scenarios followed by
// randomized event bursts checked against a set-based priority model.
module tb_vic_vector;

  import vic_pkg::*;

  localparam int NSRC = NUM_SRC;
  localparam int TMO  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        irq = 1'b0;
  logic [4:0]  irq_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        ack = 1'b0;
  logic        reti = 1'b0;

  logic        o_cpu_irq;
  logic [31:0] o_vector;
  logic [4:0]  o_cur_id;
  logic        o_in_service;
  logic        o_eoi;
  logic        o_overrun;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] vec_model [32];
  logic [31:0] pend_model;

  always #5 clk = ~clk;

  vic_vector #(
    .NUM_SRC     (NSRC),
    .ID_W        (5),
    .VEC_W       (32),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_en         (en),
    .i_irq        (irq),
    .i_irq_addr   (irq_addr),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_cpu_ack    (ack),
    .i_cpu_reti   (reti),
    .o_cpu_irq    (o_cpu_irq),
    .o_vector     (o_vector),
    .o_cur_id     (o_cur_id),
    .o_in_service (o_in_service),
    .o_eoi        (o_eoi),
    .o_overrun    (o_overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s_irq, input logic [4:0] s_addr,
                               input logic s_ack, input logic s_reti);
    irq      = s_irq;
    irq_addr = s_addr;
    ack      = s_ack;
    reti     = s_reti;
    tick();
    irq  = 1'b0;
    ack  = 1'b0;
    reti = 1'b0;
  endtask

  task automatic writeVec(input int id, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = 5'(id);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    vec_model[id] = data;
  endtask

  task automatic waitReq(input string tag);
    for (int i = 0; i < 12 && o_cpu_irq !== 1'b1; i++) tick();
    checkOutput(tag, 32'(o_cpu_irq), 32'd1);
  endtask

  task automatic serve(input int exp_id, input int ack_dly, input int reti_dly, input string tag);
    waitReq({tag, "_req"});
    checkOutput({tag, "_id"}, 32'(o_cur_id), 32'(exp_id));
    checkOutput({tag, "_vec"}, o_vector, vec_model[exp_id]);
    checkOutput({tag, "_insvc_req"}, 32'(o_in_service), 32'd1);
    repeat (ack_dly) tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput({tag, "_irq_after_ack"}, 32'(o_cpu_irq), 32'd0);
    checkOutput({tag, "_insvc_svc"}, 32'(o_in_service), 32'd1);
    repeat (reti_dly) tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput({tag, "_eoi"}, 32'(o_eoi), 32'd1);
    checkOutput({tag, "_insvc_done"}, 32'(o_in_service), 32'd0);
    tick();
    checkOutput({tag, "_eoi_low"}, 32'(o_eoi), 32'd0);
  endtask

  initial begin
    int n;
    int id;
    int low;
    logic dup;

    #12;
    checkOutput("rst_cpu_irq", 32'(o_cpu_irq), 32'd0);
    checkOutput("rst_vector", o_vector, 32'd0);
    checkOutput("rst_cur_id", 32'(o_cur_id), 32'd0);
    checkOutput("rst_in_service", 32'(o_in_service), 32'd0);
    checkOutput("rst_eoi", 32'(o_eoi), 32'd0);
    checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NSRC; i++) writeVec(i, $urandom);
    writeVec(3, 32'h100);
    writeVec(7, 32'h200);
    en = 1'b1;

    // Single event: two-cycle latency, handshake, latched vector survives a table write.
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b0);
    checkOutput("t1_irq_early", 32'(o_cpu_irq), 32'd0);
    tick();
    checkOutput("t1_irq", 32'(o_cpu_irq), 32'd1);
    checkOutput("t1_id", 32'(o_cur_id), 32'd7);
    checkOutput("t1_vec", o_vector, 32'h200);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("t1_irq_ack", 32'(o_cpu_irq), 32'd0);
    checkOutput("t1_insvc", 32'(o_in_service), 32'd1);
    writeVec(7, 32'h2A0);
    checkOutput("t1_vec_held", o_vector, 32'h200);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t1_eoi", 32'(o_eoi), 32'd1);
    checkOutput("t1_insvc_fall", 32'(o_in_service), 32'd0);
    tick();
    checkOutput("t1_eoi_one", 32'(o_eoi), 32'd0);

    // Priority: 3 before 7, request gap of DONE + IDLE.
    en = 1'b0;
    applyStimulus(1'b1, 5'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0);
    en = 1'b1;
    tick();
    checkOutput("t2_first_id", 32'(o_cur_id), 32'd3);
    checkOutput("t2_first_vec", o_vector, 32'h100);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    checkOutput("t2_gap_done", 32'(o_cpu_irq), 32'd0);
    tick();
    checkOutput("t2_gap_idle", 32'(o_cpu_irq), 32'd0);
    tick();
    checkOutput("t2_second_irq", 32'(o_cpu_irq), 32'd1);
    checkOutput("t2_second_id", 32'(o_cur_id), 32'd7);
    checkOutput("t2_second_vec", o_vector, 32'h2A0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    tick();

    // Overrun on a repeated pending ID, serviced once.
    en = 1'b0;
    applyStimulus(1'b1, 5'd5, 1'b0, 1'b0);
    checkOutput("t3_ovr_first", 32'(o_overrun), 32'd0);
    applyStimulus(1'b1, 5'd5, 1'b0, 1'b0);
    checkOutput("t3_ovr_second", 32'(o_overrun), 32'd1);
    tick();
    checkOutput("t3_ovr_pulse", 32'(o_overrun), 32'd0);
    en = 1'b1;
    serve(5, 0, 1, "t3");
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_no_repeat", 32'(o_cpu_irq), 32'd0);
      tick();
    end

    // Ack timeout: request drops after TMO cycles and is reissued.
    applyStimulus(1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < TMO; i++) begin
      checkOutput("t4_req_hold", 32'(o_cpu_irq), 32'd1);
      tick();
    end
    checkOutput("t4_dropped", 32'(o_cpu_irq), 32'd0);
    checkOutput("t4_no_eoi", 32'(o_eoi), 32'd0);
    tick();
    checkOutput("t4_reissue", 32'(o_cpu_irq), 32'd1);
    checkOutput("t4_reissue_id", 32'(o_cur_id), 32'd9);
    serve(9, 0, 0, "t4");

    // Reset during SERVICE drops everything, including a queued event.
    applyStimulus(1'b1, 5'd6, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd1, 1'b0, 1'b0);
    checkOutput("t5_in_service", 32'(o_in_service), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_insvc", 32'(o_in_service), 32'd0);
    checkOutput("t5_rst_vector", o_vector, 32'd0);
    checkOutput("t5_rst_cur_id", 32'(o_cur_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_no_dispatch", 32'(o_cpu_irq), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 5'd4, 1'b0, 1'b0);
    serve(4, 1, 0, "t5");

    // Enable gating and out-of-range ID.
    en = 1'b0;
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, EVT_ID_NONE, 1'b0, 1'b0);
    checkOutput("t6_ovr_ignored", 32'(o_overrun), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t6_disabled", 32'(o_cpu_irq), 32'd0);
      tick();
    end
    en = 1'b1;
    tick();
    checkOutput("t6_enable_irq", 32'(o_cpu_irq), 32'd1);
    serve(2, 0, 0, "t6");
    for (int i = 0; i < 3; i++) begin
      checkOutput("t6_id31_ignored", 32'(o_cpu_irq), 32'd0);
      tick();
    end

    // Random bursts collected while disabled, then drained in priority order.
    for (int r = 0; r < 6; r++) begin
      en = 1'b0;
      pend_model = '0;
      n = int'($urandom_range(3, 8));
      for (int k = 0; k < n; k++) begin
        id  = int'($urandom_range(0, 31));
        dup = (id < NSRC) && pend_model[id];
        applyStimulus(1'b1, 5'(id), 1'b0, 1'b0);
        checkOutput("rnd_overrun", 32'(o_overrun), 32'(dup));
        if (id < NSRC) pend_model[id] = 1'b1;
      end
      if ($urandom_range(0, 1) == 1) writeVec(int'($urandom_range(0, NSRC - 1)), $urandom);
      en = 1'b1;
      while (pend_model != 0) begin
        low = 0;
        while (!pend_model[low]) low++;
        serve(low, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), "rnd");
        pend_model[low] = 1'b0;
      end
      tick();
      checkOutput("rnd_drained", 32'(o_cpu_irq), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
